// File: rtl/frame_consumer_pkg.sv
// Shared types and header helpers for frame_consumer.
// Provides FSM state enum, default sync byte, length width, header slicers.
package frame_consumer_pkg;

  typedef enum logic [1:0] {
    HUNT,
    PAYLOAD,
    CHECK
  } fc_state_e;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  localparam int MAX_LEN_DEFAULT = 64;
  localparam int LEN_W = $clog2(MAX_LEN_DEFAULT + 1);

  function automatic logic [7:0] hdr_sync(input logic [15:0] w);
    return w[15:8];
  endfunction

  function automatic logic [7:0] hdr_len(input logic [15:0] w);
    return w[7:0];
  endfunction

endpackage

// File: rtl/frame_consumer_skid_buf.sv
// fc_skid_buf: 2-entry FIFO-ordered data+last buffer, valid/ready both sides.
// Ports: clk, rst, in_valid/in_ready/in_data/in_last, out_*, count (occupancy).
module fc_skid_buf #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic [1:0]   count
);

  logic [W:0] e0;
  logic [W:0] e1;
  logic       do_push;
  logic       do_pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign do_push   = in_valid && in_ready;
  assign do_pop    = out_valid && out_ready;
  assign out_last  = e0[W];
  assign out_data  = e0[W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 2'd0;
      e0    <= '0;
      e1    <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count == 2'd0) e0 <= {in_last, in_data};
          else               e1 <= {in_last, in_data};
          count <= count + 2'd1;
        end
        2'b01: begin
          e0    <= e1;
          count <= count - 2'd1;
        end
        2'b11: begin
          // Push is refused when full, so count is 1 here.
          e0 <= {in_last, in_data};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/frame_consumer.sv
// frame_consumer: pops FIFO words, parses header/payload/checksum frames.
// Ports: rclk, rrst, rpop/rdata/rempty, out_valid/ready/data/last,
// frame_done, frame_err, sync_err, frame_cnt, err_cnt.
// Macro FRAME_CONSUMER_STATS_EN builds the statistics counters.
module frame_consumer
  import frame_consumer_pkg::*;
#(
  parameter int         DATA_W  = 16,
  parameter int         MAX_LEN = 64,
  parameter logic [7:0] SYNC    = SYNC_DEFAULT,
  parameter int         CNT_W   = 16
) (
  input  logic              rclk,
  input  logic              rrst,
  output logic              rpop,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rempty,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              frame_done,
  output logic              frame_err,
  output logic              sync_err,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int LW = $clog2(MAX_LEN + 1);

  fc_state_e         state;
  logic              inflight;
  logic [1:0]        skid_cnt;
  logic [LW-1:0]     remain;
  logic [DATA_W-1:0] sum;
  logic [7:0]        len;
  logic              hdr_ok;
  logic              push;
  logic              push_last;
  logic              in_ready;

  // Reserve a buffer slot for every word already requested.
  assign rpop = !rrst && !rempty &&
                (({1'b0, skid_cnt} + {2'b00, inflight}) < 3'd2);

  assign len    = hdr_len(rdata[15:0]);
  assign hdr_ok = (hdr_sync(rdata[15:0]) == SYNC) &&
                  (len != 8'd0) && (int'(len) <= MAX_LEN);

  assign push      = inflight && (state == PAYLOAD);
  assign push_last = (remain == LW'(1));

  always_ff @(posedge rclk) begin
    if (rrst) begin
      state      <= HUNT;
      inflight   <= 1'b0;
      remain     <= '0;
      sum        <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      inflight   <= rpop;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      sync_err   <= 1'b0;
      if (inflight) begin
        case (state)
          HUNT: begin
            if (hdr_ok) begin
              remain <= LW'(len);
              sum    <= '0;
              state  <= PAYLOAD;
            end else begin
              sync_err <= 1'b1;
            end
          end
          PAYLOAD: begin
            sum    <= sum + rdata;
            remain <= remain - LW'(1);
            if (push_last) state <= CHECK;
          end
          CHECK: begin
            frame_done <= 1'b1;
            frame_err  <= (rdata != sum);
            state      <= HUNT;
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

  // The pop rule guarantees space, so in_ready never throttles a push.
  fc_skid_buf #(.W(DATA_W)) u_skid (
    .clk       (rclk),
    .rst       (rrst),
    .in_valid  (push),
    .in_ready  (in_ready),
    .in_data   (rdata),
    .in_last   (push_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .count     (skid_cnt)
  );

`ifdef FRAME_CONSUMER_STATS_EN
  always_ff @(posedge rclk) begin
    if (rrst) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (frame_done) frame_cnt <= frame_cnt + CNT_W'(1);
      err_cnt <= err_cnt + CNT_W'(frame_err) + CNT_W'(sync_err);
    end
  end
`else
  assign frame_cnt = '0;
  assign err_cnt   = '0;
`endif

  logic unused;
  assign unused = in_ready;

endmodule
